// File: rtl/lif_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_scheduler_if
// Description : Handshake, configuration and readback bundle for the
//               time-multiplexed LIF neuron scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_scheduler_if #(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 8
);

  localparam int c_IDX_W = $clog2(N_NEURONS);

  // Timestep control
  logic                 step_start;
  logic                 busy;

  // Input-current stream, one value per neuron in index order
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;

  // Threshold / beta configuration
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [WIDTH-1:0]     cfg_data;
  logic                 cfg_err;

  // Spike vector result
  logic                 spike_valid;
  logic                 spike_ready;
  logic [N_NEURONS-1:0] spike_vec;

  // Combinational membrane readback
  logic [c_IDX_W-1:0]   mem_rd_idx;
  logic [WIDTH-1:0]     mem_rd_data;

  // Side that drives timesteps and consumes spikes
  modport master (
    output step_start, in_valid, in_data, cfg_we, cfg_sel, cfg_data,
           spike_ready, mem_rd_idx,
    input  busy, in_ready, cfg_err, spike_valid, spike_vec, mem_rd_data
  );

  // Scheduler side
  modport slave (
    input  step_start, in_valid, in_data, cfg_we, cfg_sel, cfg_data,
           spike_ready, mem_rd_idx,
    output busy, in_ready, cfg_err, spike_valid, spike_vec, mem_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lif_scheduler
// Description : Leaky integrate-and-fire timestep scheduler. N neurons share
//               one update datapath: currents are streamed in (LOAD), each
//               neuron is updated one per cycle (UPDATE) and the resulting
//               spike vector is offered on a valid/ready handshake (DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module lif_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int WIDTH      = 8,
  parameter int BETA_SHIFT = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  lif_scheduler_if.slave bus
);

  localparam int                 c_IDX_W    = $clog2(N_NEURONS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_NEURONS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [WIDTH-1:0]   c_SAT      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   c_THR_RST  = WIDTH'(128);
  localparam logic [WIDTH-1:0]   c_BETA_RST = WIDTH'(14);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOAD   = 2'd1;
  localparam logic [1:0] c_UPDATE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [1:0]           w_next_state;

  logic [c_IDX_W-1:0]   r_slot;
  logic [c_IDX_W-1:0]   r_nidx;
  logic [WIDTH-1:0]     r_cur [N_NEURONS];
  logic [WIDTH-1:0]     r_mem [N_NEURONS];
  logic [WIDTH-1:0]     r_thr;
  logic [WIDTH-1:0]     r_beta;
  logic [N_NEURONS-1:0] r_spike_vec;
  logic                 r_cfg_err;

  logic                 w_busy;
  logic                 w_in_ready;
  logic                 w_spike_valid;

  logic                 w_in_accept;
  logic                 w_last_slot;
  logic                 w_last_nidx;
  logic                 w_cfg_ok;

  // --------------------------------------------------------------------------
  // LIF datapath for the neuron selected by r_nidx
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     w_v;
  logic [WIDTH-1:0]     w_i;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_shr;
  logic [WIDTH-1:0]     w_leak;
  logic [WIDTH:0]       w_sum_ext;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_fire;

  assign w_v        = r_mem[r_nidx];
  assign w_i        = r_cur[r_nidx];
  // Full-width product so large beta values act as gain without wrapping
  assign w_prod     = {{WIDTH{1'b0}}, w_v} * {{WIDTH{1'b0}}, r_beta};
  assign w_prod_shr = w_prod >> BETA_SHIFT;
  assign w_leak     = (w_prod_shr > {{WIDTH{1'b0}}, c_SAT}) ? c_SAT
                                                           : w_prod_shr[WIDTH-1:0];
  // One extra bit catches the carry of leak + current for saturation
  assign w_sum_ext  = {1'b0, w_leak} + {1'b0, w_i};
  assign w_sum      = w_sum_ext[WIDTH] ? c_SAT : w_sum_ext[WIDTH-1:0];
  // Threshold zero makes the compare always true, so every neuron fires
  assign w_fire     = (w_sum >= r_thr);

  assign w_in_accept = w_in_ready && bus.in_valid;
  assign w_last_slot = (r_slot == c_LAST_IDX);
  assign w_last_nidx = (r_nidx == c_LAST_IDX);
  assign w_cfg_ok    = (r_state == c_IDLE);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: step_start is only honoured in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.step_start) begin
          w_next_state = c_LOAD;
        end
      end
      c_LOAD: begin
        if (w_in_accept && w_last_slot) begin
          w_next_state = c_UPDATE;
        end
      end
      c_UPDATE: begin
        if (w_last_nidx) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE: begin
        if (bus.spike_ready) begin
          w_next_state = c_IDLE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Handshake outputs are pure functions of the current state
  always_comb begin
    w_busy        = 1'b0;
    w_in_ready    = 1'b0;
    w_spike_valid = 1'b0;
    case (r_state)
      c_LOAD: begin
        w_busy     = 1'b1;
        w_in_ready = 1'b1;
      end
      c_UPDATE: begin
        w_busy = 1'b1;
      end
      c_DONE: begin
        w_busy        = 1'b1;
        w_spike_valid = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration: writes land only in IDLE, otherwise flag a one-cycle error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr     <= c_THR_RST;
      r_beta    <= c_BETA_RST;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we && !w_cfg_ok;
      if (bus.cfg_we && w_cfg_ok) begin
        if (bus.cfg_sel) begin
          r_beta <= bus.cfg_data;
        end else begin
          r_thr <= bus.cfg_data;
        end
      end
    end
  end

  // Current capture: one slot per accepted beat, wrapping after the last neuron
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_cur[k] <= '0;
      end
    end else if (w_in_accept) begin
      r_cur[r_slot] <= bus.in_data;
      r_slot        <= w_last_slot ? '0 : r_slot + c_IDX_ONE;
    end
  end

  // Neuron update: write back membrane and spike bit for one neuron per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nidx      <= '0;
      r_spike_vec <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_mem[k] <= '0;
      end
    end else if (r_state == c_UPDATE) begin
      r_mem[r_nidx]       <= w_fire ? '0 : w_sum;
      r_spike_vec[r_nidx] <= w_fire;
      r_nidx              <= w_last_nidx ? '0 : r_nidx + c_IDX_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy        = w_busy;
  assign bus.in_ready    = w_in_ready;
  assign bus.spike_valid = w_spike_valid;
  assign bus.spike_vec   = r_spike_vec;
  assign bus.cfg_err     = r_cfg_err;
  // Readback sees the stored membrane, so last cycle's write is visible
  assign bus.mem_rd_data = r_mem[bus.mem_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_scheduler
// Description : Directed self-checking bench for lif_scheduler (N=8, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0]  vec;
  logic [63:0] cur;

  lif_scheduler_if #(.N_NEURONS(8), .WIDTH(8)) bus ();

  lif_scheduler #(
    .N_NEURONS (8),
    .WIDTH     (8),
    .BETA_SHIFT(4)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input int idx, input logic [7:0] exp);
    logic [2:0] sel;
    sel = idx[2:0];
    bus.mem_rd_idx = sel;
    #1;
    check_eq($sformatf("mem%0d", idx), {24'd0, bus.mem_rd_data}, {24'd0, exp});
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] val);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = val;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check_eq("cfg_idle_err", {31'd0, bus.cfg_err}, 32'd0);
  endtask

  // One full timestep; cfg_at >= 0 drives a config write on that cycle
  // (cycle 0 = the step_start cycle). hold = DONE cycles with spike_ready low.
  task automatic run_step(input logic [63:0] cur_in, input int cfg_at, input logic csel,
                          input logic [7:0] cval, input int hold, output logic [7:0] v_out);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    v_out = '0;
    @(negedge clk);
    bus.step_start = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = '0;
    bus.cfg_sel    = csel;
    bus.cfg_data   = cval;
    bus.cfg_we     = (cfg_at == 0);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      bus.step_start = 1'b0;
      bus.cfg_we     = (cyc == cfg_at);
      if (cfg_at >= 0 && cyc == cfg_at + 1)
        check_eq("cfg_err_pulse", {31'd0, bus.cfg_err}, {31'd0, (cfg_at != 0)});
      if (cfg_at > 0 && cyc == cfg_at + 2)
        check_eq("cfg_err_clear", {31'd0, bus.cfg_err}, 32'd0);
      if (bus.in_ready && k < 8) begin
        bus.in_data = cur_in[8*k +: 8];
        k++;
      end
      if (bus.spike_valid) begin
        check_eq("latency", cyc, 32'd17);
        v_out = bus.spike_vec;
        done  = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    if (!done) check_eq("step_timeout", 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      bus.step_start = 1'b1;
      @(negedge clk);
      check_eq("hold_valid", {31'd0, bus.spike_valid}, 32'd1);
      check_eq("hold_vec", {24'd0, bus.spike_vec}, {24'd0, v_out});
    end
    bus.step_start  = 1'b0;
    bus.spike_ready = 1'b1;
    @(negedge clk);
    bus.spike_ready = 1'b0;
    check_eq("handshake_valid", {31'd0, bus.spike_valid}, 32'd0);
    check_eq("handshake_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.step_start  = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_sel     = 1'b0;
    bus.cfg_data    = '0;
    bus.spike_ready = 1'b0;
    bus.mem_rd_idx  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_spike_valid", {31'd0, bus.spike_valid}, 32'd0);
    check_eq("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
    check_eq("rst_spike_vec", {24'd0, bus.spike_vec}, 32'd0);
    check_mem(0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero currents: nothing fires, membranes stay 0
    run_step(64'd0, -1, 1'b0, 8'd0, 0, vec);
    check_eq("zero_vec", {24'd0, vec}, 32'd0);
    for (int i = 0; i < 8; i++) check_mem(i, 8'd0);

    // Neuron 3 = 200, others 50; first step held in DONE with step_start poked
    cur = {8'd50, 8'd50, 8'd50, 8'd50, 8'd200, 8'd50, 8'd50, 8'd50};
    run_step(cur, -1, 1'b0, 8'd0, 5, vec);
    check_eq("s1_vec", {24'd0, vec}, 32'h08);
    check_mem(3, 8'd0);
    check_mem(0, 8'd50);
    check_mem(7, 8'd50);
    run_step(cur, -1, 1'b0, 8'd0, 0, vec);
    check_eq("s2_vec", {24'd0, vec}, 32'h08);
    check_mem(0, 8'd93);
    check_mem(3, 8'd0);
    check_mem(6, 8'd93);

    // Threshold write during UPDATE is dropped: 93*14>>4 = 81, no fire
    run_step(64'd0, 12, 1'b0, 8'd1, 0, vec);
    check_eq("cfg_upd_vec", {24'd0, vec}, 32'h00);
    check_mem(0, 8'd81);
    check_mem(3, 8'd0);

    // Beta write during LOAD is dropped: 81*14>>4 = 70
    run_step(64'd0, 4, 1'b1, 8'd1, 0, vec);
    check_eq("cfg_load_vec", {24'd0, vec}, 32'h00);
    check_mem(0, 8'd70);

    // Threshold 10 written with step_start: 70*14>>4 = 61 >= 10, neuron 3 at 0
    run_step(64'd0, 0, 1'b0, 8'd10, 0, vec);
    check_eq("cfg_start_vec", {24'd0, vec}, 32'hF7);
    check_mem(0, 8'd0);
    check_mem(3, 8'd0);

    // Saturation: beta 255, threshold 255
    cfg_write(1'b1, 8'd255);
    cfg_write(1'b0, 8'd255);
    run_step({8{8'd254}}, -1, 1'b0, 8'd0, 0, vec);
    check_eq("sat1_vec", {24'd0, vec}, 32'h00);
    check_mem(0, 8'd254);
    check_mem(5, 8'd254);
    // Neuron 0: leak alone saturates to 255; others leak+254 saturate to 255
    run_step({{7{8'd254}}, 8'd0}, -1, 1'b0, 8'd0, 0, vec);
    check_eq("sat2_vec", {24'd0, vec}, 32'hFF);
    check_mem(0, 8'd0);
    check_mem(1, 8'd0);

    // Threshold 0 fires everything
    cfg_write(1'b0, 8'd0);
    run_step(64'd0, -1, 1'b0, 8'd0, 0, vec);
    check_eq("thr0_vec", {24'd0, vec}, 32'hFF);

    // Set up nonzero state, then reset in the middle of UPDATE
    cfg_write(1'b0, 8'd200);
    cfg_write(1'b1, 8'd16);
    run_step({8'd250, {7{8'd100}}}, -1, 1'b0, 8'd0, 0, vec);
    check_eq("pre_rst_vec", {24'd0, vec}, 32'h80);
    check_mem(0, 8'd100);
    check_mem(7, 8'd0);

    @(negedge clk);
    bus.step_start = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = '0;
    @(negedge clk);
    bus.step_start = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("mid_update_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("abort_spike_valid", {31'd0, bus.spike_valid}, 32'd0);
    check_eq("abort_spike_vec", {24'd0, bus.spike_vec}, 32'd0);
    check_eq("abort_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
    for (int i = 0; i < 8; i++) check_mem(i, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("abort_no_valid", {31'd0, bus.spike_valid}, 32'd0);
    check_eq("abort_idle", {31'd0, bus.busy}, 32'd0);

    // Defaults restored: threshold 128, beta 14
    run_step(cur, -1, 1'b0, 8'd0, 0, vec);
    check_eq("post_rst_vec1", {24'd0, vec}, 32'h08);
    check_mem(0, 8'd50);
    run_step(cur, -1, 1'b0, 8'd0, 0, vec);
    check_eq("post_rst_vec2", {24'd0, vec}, 32'h08);
    check_mem(0, 8'd93);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
